fir_decim_avg: RTL

- Sits directly downstream of the FIR filter core.
- Consumes the FIR's 8-bit signed output samples and block-averages every DECIM accepted samples into one output sample, decimating the stream by DECIM.
- Results are buffered in a 2-entry output FIFO with valid/ready handshake toward the output pins or serializer.
- A sticky overflow flag reports results dropped under back-pressure.

---
 rtl/fir_decim_avg.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fir_decim_avg.sv
// Block-averaging decimator behind the FIR core: averages every DECIM accepted samples and queues results in a 2-entry FIFO.
// Define FIR_DECIM_ROUND_EN for round-half-up with saturation instead of plain floor.
module fir_decim_avg #(
  parameter int DECIM = 4,
  parameter int LOG2D = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [1:0] fifo_count,
  output logic       ovf,
  input  logic       clr_ovf
);

  localparam int AW = 8 + LOG2D;
  localparam logic [LOG2D-1:0] LAST_PHASE = LOG2D'(DECIM - 1);

  logic signed [AW-1:0] acc_q, acc_d;
  logic [LOG2D-1:0]     phase_q, phase_d;
  logic [7:0]           head_q, head_d;
  logic [7:0]           tail_q, tail_d;
  logic [1:0]           count_q, count_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic                 block_done;
  logic                 push;
  logic                 pop;
  logic signed [AW-1:0] sum;
  logic [7:0]           result;

  assign accept     = ena & in_valid;
  assign block_done = accept & (phase_q == LAST_PHASE);
  assign push       = block_done;
  assign pop        = ena & out_ready & (count_q != 2'd0);

  // A block of DECIM 8-bit samples always fits in 8+LOG2D bits, so this add never wraps.
  assign sum = acc_q + {{LOG2D{in_data[7]}}, in_data};

`ifdef FIR_DECIM_ROUND_EN
  logic signed [AW:0] sum_rnd;
  logic signed [8:0]  quot;

  always_comb begin
    sum_rnd = {sum[AW-1], sum} + (AW+1)'(1 << (LOG2D - 1));
    quot    = sum_rnd[AW:LOG2D];
    if (quot > 9'sd127)
      result = 8'h7f;
    else if (quot < -9'sd128)
      result = 8'h80;
    else
      result = quot[7:0];
  end
`else
  // Arithmetic shift right by LOG2D is just selecting the upper bits of the sum.
  assign result = sum[LOG2D +: 8];
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    acc_d   = acc_q;
    phase_d = phase_q;
    if (accept) begin
      if (block_done) begin
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = sum;
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (ena && clr_ovf)
      ovf_d = 1'b0;

    unique case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = result;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = result;
        end else if (push) begin
          tail_d  = result;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          if (push)
            tail_d = result;
          else
            count_d = 2'd1;
        end else if (push) begin
          // Full with no pop: the new result is lost; set wins over a same-cycle clear.
          ovf_d = 1'b1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      phase_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: the FIFO storage is reset too, because out_data must read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign out_valid  = (count_q != 2'd0);
  assign out_data   = head_q;
  assign fifo_count = count_q;
  assign ovf        = ovf_q;

endmodule
